// File: rtl/dot_fix_point_ctrl_if.sv
// Handshake bundle for dot_fix_point_ctrl: start/len command, operand stream, result stream.
// Master drives commands and operands; slave (the controller) drives status and result.
interface dot_fix_point_ctrl_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_1;
    logic [N-1:0]     in_2;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out;
    logic             ovf;

    modport master (
        output start, len, in_valid, in_1, in_2, out_ready,
        input  busy, in_ready, out_valid, out, ovf
    );

    modport slave (
        input  start, len, in_valid, in_1, in_2, out_ready,
        output busy, in_ready, out_valid, out, ovf
    );
endinterface

// File: rtl/dot_fix_point_ctrl.sv
// Streaming signed Q-format dot product with one-cycle product register and wide accumulator.
// Define DOT_FIX_SAT_EN to clamp the result to N bits and flag ovf; otherwise the result wraps.
module dot_fix_point_ctrl #(
    parameter int unsigned Q     = 12,
    parameter int unsigned N     = 32,
    parameter int unsigned LEN_W = 8
) (
    input logic                clk,
    input logic                rst,
    dot_fix_point_ctrl_if.slave bus
);
    localparam int unsigned AW = N + LEN_W;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [N-1:0]  prod_q, prod_d;
    logic                 prod_vld_q, prod_vld_d;

    logic signed [2*N-1:0] full_prod;
    logic signed [2*N-1:0] shifted_prod;
    logic                  accept;
    logic                  done;
    logic [N-1:0]          result;
    logic                  acc_ovf;

    assign accept       = (state_q == StLoad) && bus.in_valid;
    assign done         = (state_q == StDone);
    assign full_prod    = $signed(bus.in_1) * $signed(bus.in_2);
    assign shifted_prod = full_prod >>> Q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;

        // The product registered last cycle joins the sum now, whatever the state.
        if (prod_vld_q) begin
            acc_d = acc_q + {{LEN_W{prod_q[N-1]}}, prod_q};
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d = '0;
                    cnt_d = bus.len;
                    state_d = (bus.len == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    prod_d     = shifted_prod[N-1:0];
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
        end
    end

`ifdef DOT_FIX_SAT_EN
    logic acc_hi_zero;
    logic acc_hi_ones;
    logic [N-1:0] unused_prod_hi;

    // The sum fits in N bits exactly when the bits from N-1 upward are all equal.
    assign acc_hi_zero = ~|acc_q[AW-1:N-1];
    assign acc_hi_ones = &acc_q[AW-1:N-1];
    assign acc_ovf     = !(acc_hi_zero || acc_hi_ones);
    assign result      = !acc_ovf    ? acc_q[N-1:0] :
                         acc_q[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    assign unused_prod_hi = shifted_prod[2*N-1:N];
`else
    logic [LEN_W-1:0] unused_acc_hi;
    logic [N-1:0]     unused_prod_hi;

    assign acc_ovf        = 1'b0;
    assign result         = acc_q[N-1:0];
    assign unused_acc_hi  = acc_q[AW-1:N];
    assign unused_prod_hi = shifted_prod[2*N-1:N];
`endif

    assign bus.busy      = (state_q != StIdle);
    assign bus.in_ready  = (state_q == StLoad);
    assign bus.out_valid = done;
    assign bus.out       = done ? result : '0;
    assign bus.ovf       = done & acc_ovf;
endmodule

// File: tb/tb_dot_fix_point_ctrl.sv
// Directed bench for dot_fix_point_ctrl: hand-computed Q12 results, handshake timing and reset.
// Expected overflow behaviour follows DOT_FIX_SAT_EN when the bench is built with it.
module tb_dot_fix_point_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dot_fix_point_ctrl_if #(.N(32), .LEN_W(8)) bus ();

    dot_fix_point_ctrl #(.Q(12), .N(32), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting clock edge.
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        int k;
        bus.in_valid = 1'b1;
        bus.in_1     = a;
        bus.in_2     = b;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check_eq("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Entered one cycle after the last accept; checks DRAIN, DONE, back-pressure and return to IDLE.
    task automatic finish_run(input string tag, input logic [31:0] exp_out, input logic exp_ovf,
                              input int hold);
        check_eq({tag, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_drain_busy"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({tag, "_out"}, 64'(bus.out), 64'(exp_out));
        check_eq({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check_eq({tag, "_hold_out"}, 64'(bus.out), 64'(exp_out));
            check_eq({tag, "_hold_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] ovf_out;
        logic        ovf_flag;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_1      = '0;
        bus.in_2      = '0;
        bus.out_ready = 1'b0;
`ifdef DOT_FIX_SAT_EN
        ovf_out  = 32'h7FFF_FFFF;
        ovf_flag = 1'b1;
`else
        ovf_out  = 32'h8000_0000;
        ovf_flag = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out", 64'(bus.out), 64'd0);
        check_eq("rst_ovf", 64'(bus.ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: 2.0 + 0.25 - 1.0 = 1.25
        start_run(8'd3);
        check_eq("basic_in_ready", 64'(bus.in_ready), 64'd1);
        send_pair(32'h0000_1000, 32'h0000_2000);
        send_pair(32'h0000_0800, 32'h0000_0800);
        send_pair(32'hFFFF_F000, 32'h0000_1000);
        finish_run("basic", 32'h0000_1400, 1'b0, 0);

        // Same vectors with three idle cycles between pairs.
        start_run(8'd3);
        send_pair(32'h0000_1000, 32'h0000_2000);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall1_busy", 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        send_pair(32'h0000_0800, 32'h0000_0800);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall2_busy", 64'(bus.busy), 64'd1);
            check_eq("stall2_valid", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        send_pair(32'hFFFF_F000, 32'h0000_1000);
        finish_run("stall", 32'h0000_1400, 1'b0, 0);

        // 512.0 * 512.0 twice: 2^31 in Q12 integer units exceeds the signed 32-bit range.
        start_run(8'd2);
        send_pair(32'h0020_0000, 32'h0020_0000);
        send_pair(32'h0020_0000, 32'h0020_0000);
        finish_run("ovf", ovf_out, ovf_flag, 0);

        // Output back-pressure: 1.0 * 3.0 held for five cycles.
        start_run(8'd1);
        send_pair(32'h0000_1000, 32'h0000_3000);
        finish_run("bp", 32'h0000_3000, 1'b0, 5);

        // Zero length goes straight to DONE.
        start_run(8'd0);
        check_eq("zero_valid", 64'(bus.out_valid), 64'd1);
        check_eq("zero_out", 64'(bus.out), 64'd0);
        check_eq("zero_ovf", 64'(bus.ovf), 64'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("zero_idle", 64'(bus.busy), 64'd0);

        // Start during LOAD must not touch counter or accumulator: 1.0 + 2.0 = 3.0
        start_run(8'd2);
        send_pair(32'h0000_1000, 32'h0000_1000);
        bus.start = 1'b1;
        bus.len   = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("ign_in_ready", 64'(bus.in_ready), 64'd1);
        send_pair(32'h0000_2000, 32'h0000_1000);
        finish_run("ign", 32'h0000_3000, 1'b0, 0);

        // Asynchronous reset mid-LOAD, then a fresh single-pair run.
        start_run(8'd3);
        send_pair(32'h0000_1000, 32'h0000_2000);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mid_rst_out", 64'(bus.out), 64'd0);
        check_eq("mid_rst_ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", 64'(bus.busy), 64'd0);
        start_run(8'd1);
        send_pair(32'h0000_1000, 32'h0000_1000);
        finish_run("post_rst", 32'h0000_1000, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
